// File: rtl/cnn_layer_accel_pkg.sv
// Shared types for the CNN layer accelerator core-domain control blocks.
// Reset sequencer state and error encodings live here.
package cnn_layer_accel_pkg;

  typedef enum logic [2:0] {
    ST_RESET_HOLD,
    ST_INIT_REQ,
    ST_INIT_WAIT,
    ST_READY,
    ST_ERROR
  } rst_seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_INIT,
    ERR_TIMEOUT
  } rst_seq_err_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnn_layer_accel_rst_sequencer.sv
// Core-domain reset/init sequencer: stretches core_rst, runs the
// one-shot init handshake and reports ready or error.
module cnn_layer_accel_rst_sequencer
  import cnn_layer_accel_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int INIT_TIMEOUT    = 1024,
  parameter int RST_CNT_W       = 8
) (
  input  logic                 clk_core,
  input  logic                 rst,
  input  logic                 sw_rst_req,
  input  logic                 init_done,
  input  logic                 init_err,
  input  logic                 err_clr,
  output logic                 core_rst,
  output logic                 init_start,
  output logic                 ready,
  output logic                 busy,
  output logic [1:0]           err_code,
  output logic [RST_CNT_W-1:0] rst_count
);

  localparam int HW = cnt_w(RST_HOLD_CYCLES);
  localparam int TW = cnt_w(INIT_TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(INIT_TIMEOUT - 1);

  rst_seq_state_t       state_q, state_d;
  rst_seq_err_t         err_q, err_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [RST_CNT_W-1:0] cnt_q, cnt_d;
  logic                 core_rst_q;
  logic                 init_start_q;
  logic                 ready_q;
  logic                 busy_q;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    // Soft reset overrides every other transition.
    if (sw_rst_req) begin
      state_d = ST_RESET_HOLD;
      hold_d  = '0;
      err_d   = ERR_NONE;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end else begin
      unique case (state_q)
        ST_RESET_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_INIT_REQ;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_INIT_REQ: begin
          state_d = ST_INIT_WAIT;
          tmo_d   = '0;
        end
        ST_INIT_WAIT: begin
          tmo_d = tmo_q + 1'b1;
          if (init_err) begin
            state_d = ST_ERROR;
            err_d   = ERR_INIT;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_ERROR;
            err_d   = ERR_TIMEOUT;
          end else if (init_done) begin
            state_d = ST_READY;
          end
        end
        ST_READY: ;
        ST_ERROR: begin
          if (err_clr) begin
            state_d = ST_RESET_HOLD;
            hold_d  = '0;
            err_d   = ERR_NONE;
          end
        end
        default: begin
          state_d = ST_RESET_HOLD;
          hold_d  = '0;
          err_d   = ERR_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q      <= ST_RESET_HOLD;
      err_q        <= ERR_NONE;
      hold_q       <= '0;
      tmo_q        <= '0;
      cnt_q        <= '0;
      core_rst_q   <= 1'b1;
      init_start_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      core_rst_q   <= (state_d == ST_RESET_HOLD);
      init_start_q <= (state_d == ST_INIT_REQ);
      ready_q      <= (state_d == ST_READY);
      busy_q       <= (state_d == ST_RESET_HOLD) ||
                      (state_d == ST_INIT_REQ) ||
                      (state_d == ST_INIT_WAIT);
    end
  end

  assign core_rst   = core_rst_q;
  assign init_start = init_start_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign err_code   = err_q;
  assign rst_count  = cnt_q;

endmodule

// File: tb/tb_cnn_layer_accel_rst_sequencer.sv
// Directed bench for the core-domain reset sequencer.
// Short timeout and narrow counter expose timeout and saturation.
module tb_cnn_layer_accel_rst_sequencer;

  logic       clk_core;
  logic       rst;
  logic       sw_rst_req;
  logic       init_done;
  logic       init_err;
  logic       err_clr;
  logic       core_rst;
  logic       init_start;
  logic       ready;
  logic       busy;
  logic [1:0] err_code;
  logic [1:0] rst_count;

  int total;
  int bad;
  int hi;
  int w;
  bit seen;

  cnn_layer_accel_rst_sequencer #(
    .RST_HOLD_CYCLES(16),
    .INIT_TIMEOUT   (8),
    .RST_CNT_W      (2)
  ) dut (
    .clk_core  (clk_core),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .init_done (init_done),
    .init_err  (init_err),
    .err_clr   (err_clr),
    .core_rst  (core_rst),
    .init_start(init_start),
    .ready     (ready),
    .busy      (busy),
    .err_code  (err_code),
    .rst_count (rst_count)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic step();
    @(negedge clk_core);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_init_start();
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (init_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("init_start_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    init_done  = 1'b0;
    init_err   = 1'b0;
    err_clr    = 1'b0;
    repeat (3) step();

    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_init_start", 32'(init_start), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_count0", 32'(rst_count), 32'd0);
    rst = 1'b0;

    // Power-on hold; stray init_done during hold is ignored.
    hi = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      init_done = (hi == 3);
      if (core_rst) hi++;
      else break;
    end
    init_done = 1'b0;
    chk("po_hold_len", 32'(hi), 32'd16);
    chk("po_init_start", 32'(init_start), 32'd1);
    chk("po_req_busy", 32'(busy), 32'd1);
    step();
    chk("po_start_pulse", 32'(init_start), 32'd0);
    repeat (3) step();
    chk("po_wait_ready", 32'(ready), 32'd0);
    step();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    chk("po_ready", 32'(ready), 32'd1);
    chk("po_busy", 32'(busy), 32'd0);
    chk("po_err", 32'(err_code), 32'd0);
    chk("po_count", 32'(rst_count), 32'd0);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_ign_ready", 32'(ready), 32'd1);
    chk("clr_ign_cnt", 32'(rst_count), 32'd0);
    chk("clr_ign_crst", 32'(core_rst), 32'd0);

    // Soft reset from READY, then again five cycles into the hold.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("sw_core_rst", 32'(core_rst), 32'd1);
    chk("sw_count1", 32'(rst_count), 32'd1);
    chk("sw_ready_low", 32'(ready), 32'd0);
    hi = 1;
    repeat (4) begin
      step();
      if (core_rst) hi++;
    end
    sw_rst_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      sw_rst_req = 1'b0;
      if (core_rst) hi++;
      else break;
    end
    chk("sw_hold_len", 32'(hi), 32'd21);
    chk("sw_count2", 32'(rst_count), 32'd2);
    chk("sw_init_start", 32'(init_start), 32'd1);

    // done and err together: error wins.
    step();
    init_done = 1'b1;
    init_err  = 1'b1;
    step();
    init_done = 1'b0;
    init_err  = 1'b0;
    chk("col_err", 32'(err_code), 32'd1);
    chk("col_ready", 32'(ready), 32'd0);
    chk("col_busy", 32'(busy), 32'd0);
    step();
    chk("col_err_held", 32'(err_code), 32'd1);

    // Soft reset beats err_clr; counts once.
    sw_rst_req = 1'b1;
    err_clr    = 1'b1;
    step();
    sw_rst_req = 1'b0;
    err_clr    = 1'b0;
    chk("pri_core_rst", 32'(core_rst), 32'd1);
    chk("pri_count3", 32'(rst_count), 32'd3);
    chk("pri_err_clr", 32'(err_code), 32'd0);

    // Timeout, with init_done on the final wait cycle.
    wait_init_start();
    w = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) begin
        w++;
        init_done = (w == 8);
      end else begin
        break;
      end
    end
    init_done = 1'b0;
    chk("tmo_wait_len", 32'(w), 32'd8);
    chk("tmo_err", 32'(err_code), 32'd2);
    chk("tmo_ready", 32'(ready), 32'd0);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("eclr_core_rst", 32'(core_rst), 32'd1);
    chk("eclr_err", 32'(err_code), 32'd0);
    chk("eclr_count", 32'(rst_count), 32'd3);
    hi = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (core_rst) hi++;
      else break;
    end
    chk("eclr_hold_len", 32'(hi), 32'd16);
    chk("eclr_init_start", 32'(init_start), 32'd1);

    // Held request saturates the 2-bit counter.
    sw_rst_req = 1'b1;
    repeat (6) step();
    sw_rst_req = 1'b0;
    chk("sat_count", 32'(rst_count), 32'd3);
    chk("sat_core_rst", 32'(core_rst), 32'd1);

    // Hard reset in INIT_WAIT.
    wait_init_start();
    step();
    chk("mid_wait_busy", 32'(busy), 32'd1);
    chk("mid_wait_crst", 32'(core_rst), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_core_rst", 32'(core_rst), 32'd1);
    chk("mid_init_start", 32'(init_start), 32'd0);
    chk("mid_ready", 32'(ready), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_err", 32'(err_code), 32'd0);
    chk("mid_count", 32'(rst_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
